// File: rtl/pipe_pkg.sv
// Shared encodings for the DLX pipeline hazard/forwarding controller.
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: picks the youngest producer of rs among MEM and WB.
`default_nettype none

module fwd_sel
  import pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  output logic [1:0]      sel
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no ALU result yet, so it cannot feed EX from EX/MEM.
  assign mem_hit = mem_regwrite && !mem_memread && (mem_rd != '0) && (mem_rd == rs);
  assign wb_hit  = wb_regwrite && (wb_rd != '0) && (wb_rd == rs);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage DLX pipeline,
// including a variable-latency data-memory wait with timeout and perf counters.
`default_nettype none

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int MEM_TMO  = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  ex_rs1,
  input  logic [RA_W-1:0]  ex_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_regwrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             redirect,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0]       TMO_LAST = 8'(MEM_TMO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     state;
  logic [7:0] tmo;
  logic       freeze;
  logic       lu_ex;
  logic       lu_mem;
  logic       load_use;
  logic       redirect_taken;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .rs           (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel_a)
  );

  fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .rs           (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel_b)
  );

  // The ready cycle of a wait is the release cycle and is not frozen.
  assign freeze = ((state == ST_RUN) && mem_req && !mem_ready) ||
                  ((state == ST_MEM_WAIT) && !mem_ready);

  assign lu_ex  = ex_memread && ex_regwrite && (ex_rd != '0) &&
                  ((id_use1 && (ex_rd == id_rs1)) || (id_use2 && (ex_rd == id_rs2)));
  assign lu_mem = (LOAD_LAT == 2) && mem_memread && mem_regwrite && (mem_rd != '0) &&
                  ((id_use1 && (mem_rd == id_rs1)) || (id_use2 && (mem_rd == id_rs2)));
  assign load_use = lu_ex || lu_mem;

  assign redirect_taken = !rst && !freeze && redirect;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      ex_flush    = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (redirect) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign fwd_a = rst ? FWD_RF : sel_a;
  assign fwd_b = rst ? FWD_RF : sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      tmo       <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (redirect_taken && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
      case (state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state <= ST_MEM_WAIT;
            tmo   <= 8'd0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state <= ST_RUN;
            tmo   <= 8'd0;
          end else if (tmo == TMO_LAST) begin
            state   <= ST_RUN;
            tmo     <= 8'd0;
            mem_err <= 1'b1;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        default: begin
          state <= ST_RUN;
          tmo   <= 8'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two controllers (LOAD_LAT=1/32-bit counters, LOAD_LAT=2/3-bit counters)
// driven by the same directed vectors and checked each cycle against a behavioural model.
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int RA_W = 5;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic            id_use1, id_use2, ex_regwrite, ex_memread, mem_regwrite, mem_memread;
  logic            wb_regwrite, mem_req, mem_ready, redirect;

  logic        pc_write[2], ifid_write[2], idex_bubble[2], pipe_freeze[2];
  logic        if_flush[2], id_flush[2], ex_flush[2], mem_err[2];
  logic [1:0]  fwd_a[2], fwd_b[2];
  logic [31:0] a_stall, a_flush;
  logic [2:0]  b_stall, b_flush;

  pipe_hazard_ctrl #(.RA_W(RA_W), .LOAD_LAT(1), .MEM_TMO(TMO), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .redirect(redirect), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]),
    .idex_bubble(idex_bubble[0]), .pipe_freeze(pipe_freeze[0]), .if_flush(if_flush[0]),
    .id_flush(id_flush[0]), .ex_flush(ex_flush[0]), .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]),
    .mem_err(mem_err[0]), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_hazard_ctrl #(.RA_W(RA_W), .LOAD_LAT(2), .MEM_TMO(TMO), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .redirect(redirect), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]),
    .idex_bubble(idex_bubble[1]), .pipe_freeze(pipe_freeze[1]), .if_flush(if_flush[1]),
    .id_flush(id_flush[1]), .ex_flush(ex_flush[1]), .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]),
    .mem_err(mem_err[1]), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       pc_write, ifid_write, idex_bubble, pipe_freeze, if_flush, id_flush, ex_flush;
    logic [1:0] fwd_a, fwd_b;
  } exp_t;

  bit     model_valid = 0;
  bit     m_waiting   = 0;
  int     m_waited    = 0;
  bit     m_err       = 0;
  longint m_stall[2]  = '{0, 0};
  longint m_flush[2]  = '{0, 0};
  longint m_max[2]    = '{64'hFFFF_FFFF, 7};

  function automatic bit hits_id(logic [RA_W-1:0] rd);
    return (id_use1 && rd == id_rs1) || (id_use2 && rd == id_rs2);
  endfunction

  function automatic logic [1:0] fwd_of(logic [RA_W-1:0] rs);
    if (mem_regwrite && !mem_memread && mem_rd != 0 && mem_rd == rs) return 2'd2;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t model_out(int lat);
    exp_t e;
    bit frozen, lu;
    e = '{pc_write: 1, ifid_write: 1, default: '0};
    frozen = m_waiting ? !mem_ready : (mem_req && !mem_ready);
    lu = (ex_memread && ex_regwrite && ex_rd != 0 && hits_id(ex_rd)) ||
         (lat == 2 && mem_memread && mem_regwrite && mem_rd != 0 && hits_id(mem_rd));
    if (rst) begin
      e.pc_write = 0; e.ifid_write = 0; e.idex_bubble = 1;
      e.if_flush = 1; e.id_flush = 1; e.ex_flush = 1;
      return e;
    end
    e.fwd_a = fwd_of(ex_rs1);
    e.fwd_b = fwd_of(ex_rs2);
    if (frozen) begin
      e.pc_write = 0; e.ifid_write = 0; e.pipe_freeze = 1;
    end else if (redirect) begin
      e.if_flush = 1; e.id_flush = 1; e.ex_flush = 1;
    end else if (lu) begin
      e.pc_write = 0; e.ifid_write = 0; e.idex_bubble = 1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      model_valid = 1; m_waiting = 0; m_waited = 0; m_err = 0;
      m_stall = '{0, 0}; m_flush = '{0, 0};
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = model_out(k + 1);
        if (!e.pc_write && m_stall[k] < m_max[k]) m_stall[k]++;
        if (e.if_flush && m_flush[k] < m_max[k]) m_flush[k]++;
      end
      if (!m_waiting) begin
        if (mem_req && !mem_ready) begin m_waiting = 1; m_waited = 0; end
      end else if (mem_ready) begin
        m_waiting = 0;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin m_err = 1; m_waiting = 0; end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (model_valid) begin
      for (int k = 0; k < 2; k++) begin
        e = model_out(k + 1);
        check($sformatf("pc_write[%0d]", k),    32'(pc_write[k]),    32'(e.pc_write));
        check($sformatf("ifid_write[%0d]", k),  32'(ifid_write[k]),  32'(e.ifid_write));
        check($sformatf("idex_bubble[%0d]", k), 32'(idex_bubble[k]), 32'(e.idex_bubble));
        check($sformatf("pipe_freeze[%0d]", k), 32'(pipe_freeze[k]), 32'(e.pipe_freeze));
        check($sformatf("if_flush[%0d]", k),    32'(if_flush[k]),    32'(e.if_flush));
        check($sformatf("id_flush[%0d]", k),    32'(id_flush[k]),    32'(e.id_flush));
        check($sformatf("ex_flush[%0d]", k),    32'(ex_flush[k]),    32'(e.ex_flush));
        check($sformatf("fwd_a[%0d]", k),       32'(fwd_a[k]),       32'(e.fwd_a));
        check($sformatf("fwd_b[%0d]", k),       32'(fwd_b[k]),       32'(e.fwd_b));
        check($sformatf("mem_err[%0d]", k),     32'(mem_err[k]),     32'(m_err));
      end
      check("stall_cnt[0]", a_stall,       32'(m_stall[0]));
      check("flush_cnt[0]", a_flush,       32'(m_flush[0]));
      check("stall_cnt[1]", 32'(b_stall),  32'(m_stall[1]));
      check("flush_cnt[1]", 32'(b_flush),  32'(m_flush[1]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use1, id_use2, ex_regwrite, ex_memread, mem_regwrite, mem_memread} = '0;
    {wb_regwrite, mem_req, mem_ready, redirect} = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use_ex(input logic [RA_W-1:0] rd);
    ex_memread = 1; ex_regwrite = 1; ex_rd = rd; id_rs1 = rd; id_use1 = 1;
  endtask

  initial begin
    clr();
    rst = 1;
    nxt(); nxt();
    @(negedge clk);
    check("lit_rst_pc_write", 32'(pc_write[0]), 0);
    check("lit_rst_if_flush", 32'(if_flush[0]), 1);
    check("lit_rst_ex_flush", 32'(ex_flush[1]), 1);
    check("lit_rst_stall",    a_stall, 0);
    check("lit_rst_flush",    a_flush, 0);
    nxt(); rst = 0;
    @(negedge clk);
    check("lit_run_pc_write", 32'(pc_write[0]), 1);
    check("lit_run_fwd_a",    32'(fwd_a[0]), 0);

    // load-use in EX, then the same with rd=0
    nxt(); set_load_use_ex(5);
    @(negedge clk);
    check("lit_lu_pc_write", 32'(pc_write[0]), 0);
    check("lit_lu_bubble",   32'(idex_bubble[0]), 1);
    nxt(); clr();
    @(negedge clk);
    check("lit_lu_stall_cnt", a_stall, 1);
    check("lit_lu_released",  32'(pc_write[0]), 1);
    nxt(); set_load_use_ex(0);
    @(negedge clk);
    check("lit_lu_r0_pc_write", 32'(pc_write[0]), 1);
    nxt(); clr();

    // forwarding priority and register 0
    mem_rd = 7; wb_rd = 7; ex_rs2 = 7; mem_regwrite = 1; wb_regwrite = 1;
    @(negedge clk);
    check("lit_fwd_b_mem", 32'(fwd_b[0]), 2);
    nxt(); mem_memread = 1;
    @(negedge clk);
    check("lit_fwd_b_wb", 32'(fwd_b[0]), 1);
    nxt(); clr();
    mem_regwrite = 1; wb_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 3;
    @(negedge clk);
    check("lit_fwd_a_r0", 32'(fwd_a[0]), 0);
    nxt(); clr();
    wb_regwrite = 1; wb_rd = 3; ex_rs1 = 3;
    @(negedge clk);
    check("lit_fwd_a_wb", 32'(fwd_a[0]), 1);
    nxt(); clr();

    // load in MEM: only the LOAD_LAT=2 instance stalls
    mem_memread = 1; mem_regwrite = 1; mem_rd = 9; id_rs2 = 9; id_use2 = 1;
    @(negedge clk);
    check("lit_ll1_pc_write", 32'(pc_write[0]), 1);
    check("lit_ll2_pc_write", 32'(pc_write[1]), 0);
    check("lit_ll2_bubble",   32'(idex_bubble[1]), 1);
    nxt(); clr();
    @(negedge clk);
    check("lit_ll1_stall", a_stall, 1);
    check("lit_ll2_stall", 32'(b_stall), 2);

    // memory wait with redirect held high
    nxt(); mem_req = 1; redirect = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lit_wait_freeze", 32'(pipe_freeze[0]), 1);
      check("lit_wait_noflush", 32'(if_flush[0]), 0);
      nxt();
    end
    mem_ready = 1;
    @(negedge clk);
    check("lit_ready_flush",  32'(if_flush[0]), 1);
    check("lit_ready_freeze", 32'(pipe_freeze[0]), 0);
    nxt(); clr();
    @(negedge clk);
    check("lit_wait_flush_cnt", a_flush, 1);
    check("lit_wait_stall_cnt", a_stall, 4);

    // timeout: entry cycle + TMO wait cycles
    nxt(); mem_req = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lit_tmo_err_low", 32'(mem_err[0]), 0);
      nxt();
    end
    mem_req = 0;
    @(negedge clk);
    check("lit_tmo_err",     32'(mem_err[0]), 1);
    check("lit_tmo_run",     32'(pc_write[0]), 1);
    check("lit_tmo_stall",   a_stall, 9);
    check("lit_tmo_stall_b", 32'(b_stall), 7);
    nxt();
    @(negedge clk);
    check("lit_tmo_sticky", 32'(mem_err[0]), 1);

    // redirect beats load-use; drives flush_cnt of instance B into saturation
    nxt(); set_load_use_ex(6); redirect = 1;
    @(negedge clk);
    check("lit_redir_bubble", 32'(idex_bubble[0]), 0);
    check("lit_redir_pc",     32'(pc_write[0]), 1);
    repeat (7) nxt();
    nxt(); clr();
    @(negedge clk);
    check("lit_flush_a",   a_flush, 9);
    check("lit_flush_sat", 32'(b_flush), 7);

    // reset in the middle of a memory wait
    nxt(); mem_req = 1;
    nxt(); nxt(); rst = 1;
    @(negedge clk);
    check("lit_rstw_freeze", 32'(pipe_freeze[0]), 0);
    check("lit_rstw_pc",     32'(pc_write[0]), 0);
    nxt(); rst = 0; mem_req = 0;
    @(negedge clk);
    check("lit_rstw_run",   32'(pc_write[0]), 1);
    check("lit_rstw_err",   32'(mem_err[0]), 0);
    check("lit_rstw_stall", a_stall, 0);
    check("lit_rstw_flush", a_flush, 0);
    nxt(); nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
